// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  function automatic logic is_req(input logic re, input logic [WE_W-1:0] we);
    return re | (|we);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles m1 has been kept off the bus.
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt;

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master bus arbiter: m0 normally wins, m1 is protected from starvation
// by a saturating wait counter and may hold the bus with m1_lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [WE_W-1:0]   m0_we,
  input  logic              m0_re,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [WE_W-1:0]   m1_we,
  input  logic              m1_re,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [WE_W-1:0]   s_we,
  output logic              s_re,
  input  logic [DATA_W-1:0] s_rdata
);

  lock_state_t state;
  logic        req0, req1, force1, wait_sat;
  logic        gnt0, gnt1;
  logic        owner_q, rd_q;

  assign req0   = is_req(m0_re, m0_we);
  assign req1   = is_req(m1_re, m1_we);
  assign force1 = wait_sat | (state == LOCKED);

  // Grants are suppressed while reset is held so nothing reaches the bus.
  assign gnt0   = reset & req0 & ~(force1 & req1);
  assign gnt1   = reset & req1 & ~gnt0;
  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (req1 & ~gnt1),
    .clr   (gnt1),
    .sat   (wait_sat)
  );

  always_comb begin
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_we    = '0;
    s_re    = 1'b0;
    if (gnt1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_we    = m1_we;
      s_re    = m1_re;
    end else if (gnt0) begin
      s_we    = m0_we;
      s_re    = m0_re;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= NORMAL;
    end else begin
      case (state)
        NORMAL:  if (gnt1 && m1_lock) state <= LOCKED;
        LOCKED:  if (!m1_lock)        state <= NORMAL;
        default:                      state <= NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      owner_q <= M0;
    end else begin
      rd_q    <= s_re;
      owner_q <= gnt1 ? M1 : M0;
    end
  end

  // Gating with reset drops a response whose return cycle falls inside reset.
  assign m0_rvalid = reset & rd_q & (owner_q == M0);
  assign m1_rvalid = reset & rd_q & (owner_q == M1);
  assign rdata     = s_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_wdata, m1_wdata, s_wdata, rdata;
  logic [31:0] s_rdata = 32'h0;
  logic [3:0]  m0_we, m1_we, s_we;
  logic        m0_re, m1_re, m1_lock, s_re;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;

  int total = 0;
  int bad   = 0;

  // Outstanding read expected to return in the current cycle.
  logic        pend0 = 1'b0;
  logic        pend1 = 1'b0;
  logic [29:0] pend_addr = '0;

  mem_arbiter #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_we     (m0_we),
    .m0_re     (m0_re),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_we     (m1_we),
    .m1_re     (m1_re),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .rdata     (rdata),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_we      (s_we),
    .s_re      (s_re),
    .s_rdata   (s_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (s_re) s_rdata <= ram_word(s_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [3:0] w0, input logic [29:0] a0,
                               input logic r1, input logic [3:0] w1, input logic [29:0] a1,
                               input logic lk);
    m0_re   = r0;
    m0_we   = w0;
    m0_addr = a0;
    m1_re   = r1;
    m1_we   = w1;
    m1_addr = a1;
    m1_lock = lk;
  endtask

  // Checks one cycle's grants, bus mirror and read return, then steps to just after the next edge.
  task automatic run_cycle(input logic exp_g0, input logic exp_g1);
    logic       exp_re;
    logic [3:0] exp_we;
    #3;
    exp_re = exp_g0 ? m0_re : (exp_g1 ? m1_re : 1'b0);
    exp_we = exp_g0 ? m0_we : (exp_g1 ? m1_we : 4'h0);
    checkOutput("m0_gnt", m0_gnt, exp_g0);
    checkOutput("m1_gnt", m1_gnt, exp_g1);
    checkOutput("m0_rvalid", m0_rvalid, pend0);
    checkOutput("m1_rvalid", m1_rvalid, pend1);
    if (pend0 || pend1) checkOutput("rdata", rdata, ram_word(pend_addr));
    checkOutput("s_re", s_re, exp_re);
    checkOutput("s_we", s_we, exp_we);
    if (exp_g1) begin
      checkOutput("s_addr_m1", s_addr, m1_addr);
      checkOutput("s_wdata_m1", s_wdata, m1_wdata);
    end else if (exp_g0) begin
      checkOutput("s_addr_m0", s_addr, m0_addr);
    end
    pend0     = exp_g0 & m0_re;
    pend1     = exp_g1 & m1_re;
    pend_addr = exp_g0 ? m0_addr : m1_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    m0_wdata = 32'h1111_2222;
    m1_wdata = 32'hDEAD_BEEF;
    applyStimulus(1, 4'h0, 30'h10, 1, 4'h0, 30'h30, 0);
    @(posedge clk);
    #4;
    checkOutput("rst_m0_gnt", m0_gnt, 1'b0);
    checkOutput("rst_m1_gnt", m1_gnt, 1'b0);
    checkOutput("rst_s_re", s_re, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0, 4'h0, 30'h0, 0, 4'h0, 30'h0, 0);
    checkOutput("rst_wait_cnt", dut.u_starve.cnt, 8'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(NORMAL));

    // m0 alone streams reads
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'h0, 30'h10, 0, 4'h0, 30'h0, 0);
      run_cycle(1'b1, 1'b0);
    end
    applyStimulus(0, 4'h0, 30'h0, 0, 4'h0, 30'h0, 0);
    run_cycle(1'b0, 1'b0);

    // both request: four m0 grants, then m1 forced
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 4'h0, 30'h20, 1, 4'h0, 30'h30, 0);
      checkOutput("wait_cnt_fair", dut.u_starve.cnt, 32'(i % 5));
      run_cycle((i % 5) != 4, (i % 5) == 4);
    end
    applyStimulus(0, 4'h0, 30'h0, 0, 4'h0, 30'h0, 0);
    run_cycle(1'b0, 1'b0);

    // locked write burst, lock released on the last beat
    applyStimulus(0, 4'h0, 30'h0,  0, 4'hF, 30'h40, 1); run_cycle(1'b0, 1'b1);
    applyStimulus(1, 4'h0, 30'h50, 0, 4'hF, 30'h41, 1); run_cycle(1'b0, 1'b1);
    applyStimulus(1, 4'h0, 30'h50, 0, 4'hF, 30'h42, 0); run_cycle(1'b0, 1'b1);
    applyStimulus(1, 4'h0, 30'h50, 0, 4'h0, 30'h0,  0); run_cycle(1'b1, 1'b0);
    // locked but idle m1 lets m0 through, then the lock still forces m1
    applyStimulus(0, 4'h0, 30'h0,  0, 4'hF, 30'h43, 1); run_cycle(1'b0, 1'b1);
    applyStimulus(1, 4'h0, 30'h51, 0, 4'h0, 30'h0,  1); run_cycle(1'b1, 1'b0);
    checkOutput("wait_cnt_hold", dut.u_starve.cnt, 8'd0);
    applyStimulus(1, 4'h0, 30'h51, 1, 4'h0, 30'h44, 0); run_cycle(1'b0, 1'b1);
    applyStimulus(1, 4'h0, 30'h51, 1, 4'h0, 30'h45, 0); run_cycle(1'b1, 1'b0);
    applyStimulus(0, 4'h0, 30'h0,  1, 4'h0, 30'h45, 0); run_cycle(1'b0, 1'b1);
    applyStimulus(0, 4'h0, 30'h0,  0, 4'h0, 30'h0,  0); run_cycle(1'b0, 1'b0);

    // alternating back-to-back reads, no cross delivery
    applyStimulus(1, 4'h0, 30'h60, 0, 4'h0, 30'h0,  0); run_cycle(1'b1, 1'b0);
    applyStimulus(0, 4'h0, 30'h0,  1, 4'h0, 30'h70, 0); run_cycle(1'b0, 1'b1);
    applyStimulus(0, 4'h0, 30'h0,  0, 4'h0, 30'h0,  0); run_cycle(1'b0, 1'b0);

    // reset right after a locked m1 read drops the response
    applyStimulus(0, 4'h0, 30'h0, 1, 4'h0, 30'h80, 1); run_cycle(1'b0, 1'b1);
    reset = 1'b0;
    applyStimulus(1, 4'h0, 30'h90, 1, 4'h0, 30'hA0, 1);
    #3;
    checkOutput("rstrd_m1_rvalid", m1_rvalid, 1'b0);
    checkOutput("rstrd_m0_rvalid", m0_rvalid, 1'b0);
    checkOutput("rstrd_m0_gnt", m0_gnt, 1'b0);
    checkOutput("rstrd_m1_gnt", m1_gnt, 1'b0);
    checkOutput("rstrd_s_we", s_we, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1, 4'h0, 30'h90, 1, 4'h0, 30'hA0, 0);
    pend0 = 1'b0;
    pend1 = 1'b0;
    checkOutput("post_rst_state", 32'(dut.state), 32'(NORMAL));
    checkOutput("post_rst_wait_cnt", dut.u_starve.cnt, 8'd0);
    run_cycle(1'b1, 1'b0);
    applyStimulus(0, 4'h0, 30'h0, 1, 4'h0, 30'hA0, 0); run_cycle(1'b0, 1'b1);
    applyStimulus(0, 4'h0, 30'h0, 0, 4'h0, 30'h0,  0); run_cycle(1'b0, 1'b0);

    // m1 alone is granted immediately and never accumulates wait
    applyStimulus(0, 4'h0, 30'h0, 0, 4'hF, 30'hB0, 0);
    checkOutput("solo_wait_pre", dut.u_starve.cnt, 8'd0);
    run_cycle(1'b0, 1'b1);
    applyStimulus(0, 4'h0, 30'h0, 0, 4'h0, 30'h0, 0);
    checkOutput("solo_wait_post", dut.u_starve.cnt, 8'd0);
    run_cycle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM/peripheral bus port between two requesters: m0 (CPU, normally high priority) and m1 (DMA/loader engine).
- Sits between the requesters and the address decode / RAM in the top level.
- Issues at most one access per cycle, returns read data to its owner one cycle after the read, and prevents m1 starvation with a wait counter and an optional lock.

Parameters:
- MAX_WAIT, 4: consecutive cycles m1 may be denied before it is forced to win the next arbitration (1..255).
- WAIT_W, 8: width of the wait counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- m0_addr  in  30  m0 word address
- m0_wdata  in  32  m0 write data
- m0_we  in  4  m0 byte write enables
- m0_re  in  1  m0 read enable
- m0_gnt  out  1  m0 access accepted this cycle
- m0_rvalid  out  1  m0 read data valid
- m1_addr  in  30  m1 word address
- m1_wdata  in  32  m1 write data
- m1_we  in  4  m1 byte write enables
- m1_re  in  1  m1 read enable
- m1_lock  in  1  m1 holds the bus across consecutive accesses
- m1_gnt  out  1  m1 access accepted this cycle
- m1_rvalid  out  1  m1 read data valid
- rdata  out  32  read data to both masters (qualified by mX_rvalid)
- s_addr  out  30  bus address
- s_wdata  out  32  bus write data
- s_we  out  4  bus write enables
- s_re  out  1  bus read enable
- s_rdata  in  32  bus read data, valid the cycle after s_re

Behaviour:
- Request: reqN = mN_re | (|mN_we). re and we must not both be set on one master.
- Handshake: a master holds its address, data, re and we stable until it sees gnt=1 in the same cycle. It may drop the request only after being granted.
- Grant is combinational from the request lines and registered state:
  - force1 = (wait_cnt == MAX_WAIT) | (state == LOCKED).
  - gnt0 = req0 & ~(force1 & req1).
  - gnt1 = req1 & ~gnt0.
- Slave side:
  - s_* mirror the granted master.
  - With no grant: s_re=0 and s_we=0. s_addr and s_wdata are don't-care but are driven from m0.
- Read return:
  - owner_q <= granted master id; rd_q <= granted s_re.
  - Next cycle: mN_rvalid = rd_q & (owner_q==N); rdata = s_rdata unmodified.
  - Latency is exactly 1 cycle after the grant.
  - Back-to-back grants are allowed every cycle, including alternating masters.
- Wait counter (WAIT_W bits):
  - Increments on each cycle with req1 & ~gnt1, saturating at MAX_WAIT.
  - Clears to 0 on gnt1.
  - Holds when req1=0.
- Lock state machine:
  - States: NORMAL, LOCKED.
  - NORMAL -> LOCKED on gnt1 & m1_lock.
  - LOCKED -> NORMAL when m1_lock=0 is sampled, or when req1=0 with m1_lock=0.
  - While LOCKED with req1=0, m0 may still be granted, so an idle m1 gives no bus starvation.
- Simultaneous requests:
  - Both request, force1=0: m0 wins and wait_cnt increments.
  - Both request, force1=1: m1 wins and wait_cnt clears.
- Reset (reset=0 at a clock edge): state=NORMAL, wait_cnt=0, rd_q=0, owner_q=0.
- While reset is low: m0_gnt=m1_gnt=0, s_re=0, s_we=0, m0_rvalid=m1_rvalid=0, rdata = s_rdata (don't-care).
- Reset asserted the cycle after a granted read: the read response is dropped and no rvalid is issued.

Decomposition:
- Shared package (or header):
  - Master id constants M0=0, M1=1.
  - State encodings NORMAL/LOCKED.
  - REQ_W for the bus field widths (30/32/4).
- One sub-module is natural: arb_starve_cnt, holding the saturating wait counter with inc/clr/sat outputs.
- The muxing and the lock FSM stay in mem_arbiter.

Test Plan:
- Only m0 reads addr 0x10 every cycle for 5 cycles -> m0_gnt=1 each cycle; m0_rvalid=1 from cycle 2; rdata matches RAM model; m1_rvalid=0 throughout.
- m0 and m1 both request continuously with MAX_WAIT=4 -> grant pattern is m0 for 4 cycles, then m1 for 1 cycle, repeating; wait_cnt returns to 0 after each m1 grant.
- m1 writes 0xDEADBEEF with we=4'hF and m1_lock=1 for 3 accesses while m0 requests -> m1 granted 3 consecutive cycles; m0 granted on the cycle after m1_lock drops.
- m0 read granted in cycle N, then m1 read granted in cycle N+1 -> m0_rvalid in N+1, m1_rvalid in N+2, each with the correct s_rdata; no cross-delivery.
- m1 read granted, then reset=0 asserted on the next edge -> no rvalid issued; after reset is released, state=NORMAL, wait_cnt=0, and the first simultaneous request goes to m0.
- m1 requests while m0 is idle -> m1_gnt=1 in the same cycle; wait_cnt stays 0.
